// File: rtl/gate_sweep_ctrl.sv
// Sweeps an N_IN-input gate under test through every input vector in ascending
// order, samples its output after a settle time and scores it against EXPECT.
module gate_sweep_ctrl #(
  parameter int                  N_IN       = 2,
  parameter int                  SETTLE_CYC = 2,
  parameter logic [2**N_IN-1:0]  EXPECT     = 4'b0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic [N_IN-1:0]      gate_in,
  input  logic                 gate_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_cnt,
  output logic [2**N_IN-1:0]   result_vec,
  output logic [1:0]           state_dbg
);

  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;

  // Handshake: start is a level looked at only in IDLE (no queuing); done is a
  // single-cycle pulse with no backpressure; abort overrides start everywhere.
  state_t                state_q, state_d;
  logic [N_IN-1:0]       idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [N_IN-1:0]       gate_in_d;
  logic                  busy_d, done_d, pass_d;
  logic [N_IN:0]         mcnt_d;
  logic [NV-1:0]         result_d;
  logic                  sample_now;
  logic                  start_ok;

  assign state_dbg  = state_q;
  assign sample_now = (state_q == SAMPLE) && !abort;
  assign start_ok   = (state_q == IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      gate_in      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      mismatch_cnt <= '0;
      result_vec   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      gate_in      <= gate_in_d;
      busy         <= busy_d;
      done         <= done_d;
      pass         <= pass_d;
      mismatch_cnt <= mcnt_d;
      result_vec   <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = DRIVE;
      DRIVE: begin
        if (abort)                                 state_d = IDLE;
        else if (cnt_q == CW'(SETTLE_CYC - 1))     state_d = SAMPLE;
      end
      SAMPLE: begin
        if (abort)                                 state_d = IDLE;
        else if (idx_q == N_IN'(NV - 1))           state_d = DONE;
        else                                       state_d = DRIVE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath, derived from state_d so
  // every output lines up with the state it belongs to.
  always_comb begin
    idx_d    = idx_q;
    cnt_d    = '0;
    result_d = result_vec;
    mcnt_d   = mismatch_cnt;
    pass_d   = pass;

    if (start_ok) begin
      idx_d    = '0;
      result_d = '0;
      mcnt_d   = '0;
      pass_d   = 1'b0;
    end

    if (state_q == DRIVE && state_d == DRIVE) cnt_d = cnt_q + CW'(1);

    if (sample_now) begin
      result_d[idx_q] = gate_out;
      if (gate_out != EXPECT[idx_q]) mcnt_d = mismatch_cnt + (N_IN+1)'(1);
      if (state_d == DRIVE) idx_d = idx_q + N_IN'(1);
    end

    if (state_q != IDLE && abort) pass_d = 1'b0;
    if (state_q == SAMPLE && state_d == DONE) pass_d = (mcnt_d == '0);

    busy_d    = (state_d == DRIVE) || (state_d == SAMPLE);
    done_d    = (state_d == DONE);
    gate_in_d = busy_d ? idx_d : '0;
  end

endmodule
